f1_reaction_timer: RTL

Parametrised F1 start-light reaction timer. It generates the light-up sequence from a programmable prescaler. It holds all lights on for a pseudo-random number of ticks, switches them off, then measures clock cycles until the player's react input. It adds false-start detection, a saturating timeout and a registered result with valid flag, and sits directly under the board-level top.

---
 rtl/f1_timer_pkg.sv | 39 +++
 rtl/f1_lfsr.sv | 29 ++
 rtl/f1_reaction_timer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/f1_timer_pkg.sv
//------------------------------------------------------------------------------
// f1_timer_pkg - shared FSM state type and LFSR tap table. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package f1_timer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEQ     = 3'd1,
    HOLD    = 3'd2,
    MEASURE = 3'd3,
    DONE    = 3'd4,
    FAULT   = 3'd5
  } state_t;

  // Maximal-length Fibonacci taps; bit (width-1) is the MSB of the register.
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      4:       lfsr_taps = 16'h000C;
      5:       lfsr_taps = 16'h0014;
      6:       lfsr_taps = 16'h0030;
      7:       lfsr_taps = 16'h0060;
      8:       lfsr_taps = 16'h00B8;
      9:       lfsr_taps = 16'h0110;
      10:      lfsr_taps = 16'h0240;
      11:      lfsr_taps = 16'h0500;
      12:      lfsr_taps = 16'h0829;
      13:      lfsr_taps = 16'h100D;
      14:      lfsr_taps = 16'h2015;
      15:      lfsr_taps = 16'h6000;
      16:      lfsr_taps = 16'hD008;
      default: lfsr_taps = 16'h000C;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/f1_lfsr.sv
//------------------------------------------------------------------------------
// f1_lfsr - free-running Fibonacci LFSR, seeded to 1, never all-zero. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module f1_lfsr
  import f1_timer_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] value
);

  localparam logic [15:0]      TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      value <= {value[WIDTH-2:0], ^(value & TAPS)};
    end
  end

endmodule

`default_nettype wire

// File: rtl/f1_reaction_timer.sv
//------------------------------------------------------------------------------
// f1_reaction_timer - F1 start-light sequencer and reaction timer. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module f1_reaction_timer
  import f1_timer_pkg::*;
#(
  parameter int N_LIGHTS    = 8,
  parameter int TICK_WIDTH  = 16,
  parameter int RAND_WIDTH  = 7,
  parameter int REACT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [TICK_WIDTH-1:0]  tick_div,
  input  logic                   react,
  output logic [N_LIGHTS-1:0]    lights,
  output logic                   busy,
  output logic [REACT_WIDTH-1:0] react_time,
  output logic                   result_valid,
  output logic                   false_start
);

  localparam logic [REACT_WIDTH-1:0] REACT_MAX  = '1;
  localparam logic [REACT_WIDTH-1:0] REACT_LAST = {{(REACT_WIDTH-1){1'b1}}, 1'b0};

  state_t                 state, state_nxt;
  logic [TICK_WIDTH-1:0]  presc, presc_nxt;
  logic [RAND_WIDTH-1:0]  hold_cnt, hold_nxt;
  logic [REACT_WIDTH-1:0] react_cnt, react_cnt_nxt;
  logic [N_LIGHTS-1:0]    lights_nxt;
  logic [REACT_WIDTH-1:0] react_time_nxt;
  logic                   result_valid_nxt;
  logic                   false_start_nxt;
  logic                   busy_nxt;
  logic [RAND_WIDTH-1:0]  lfsr_value;
  logic                   tick;

  f1_lfsr #(
    .WIDTH (RAND_WIDTH)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_value)
  );

  assign tick = ((state == SEQ) || (state == HOLD)) && (presc == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc        <= '0;
      hold_cnt     <= '0;
      react_cnt    <= '0;
      lights       <= '0;
      react_time   <= '0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      presc        <= presc_nxt;
      hold_cnt     <= hold_nxt;
      react_cnt    <= react_cnt_nxt;
      lights       <= lights_nxt;
      react_time   <= react_time_nxt;
      result_valid <= result_valid_nxt;
      false_start  <= false_start_nxt;
      busy         <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    presc_nxt        = presc;
    hold_nxt         = hold_cnt;
    react_cnt_nxt    = react_cnt;
    lights_nxt       = lights;
    react_time_nxt   = react_time;
    result_valid_nxt = result_valid;
    false_start_nxt  = false_start;

    // The prescaler only advances while lights are sequencing or holding.
    if ((state == SEQ) || (state == HOLD)) begin
      presc_nxt = tick ? tick_div : (presc - TICK_WIDTH'(1));
    end

    case (state)
      IDLE, DONE, FAULT: begin
        if (start) begin
          state_nxt        = SEQ;
          presc_nxt        = tick_div;
          lights_nxt       = '0;
          react_time_nxt   = '0;
          result_valid_nxt = 1'b0;
          false_start_nxt  = 1'b0;
        end
      end
      SEQ: begin
        if (react) begin
          state_nxt       = FAULT;
          lights_nxt      = '1;
          false_start_nxt = 1'b1;
        end else if (tick) begin
          if (&lights) begin
            state_nxt = HOLD;
            hold_nxt  = (lfsr_value == '0) ? RAND_WIDTH'(1) : lfsr_value;
          end else begin
            lights_nxt = {lights[N_LIGHTS-2:0], 1'b1};
          end
        end
      end
      HOLD: begin
        if (react) begin
          state_nxt       = FAULT;
          lights_nxt      = '1;
          false_start_nxt = 1'b1;
        end else if (tick) begin
          if (hold_cnt == RAND_WIDTH'(1)) begin
            state_nxt     = MEASURE;
            lights_nxt    = '0;
            react_cnt_nxt = '0;
          end else begin
            hold_nxt = hold_cnt - RAND_WIDTH'(1);
          end
        end
      end
      MEASURE: begin
        if (react) begin
          state_nxt        = DONE;
          react_time_nxt   = react_cnt;
          result_valid_nxt = 1'b1;
        end else if ((react_cnt == REACT_LAST) || (react_cnt == REACT_MAX)) begin
          // The increment that would reach all ones doubles as the timeout.
          state_nxt        = DONE;
          react_cnt_nxt    = REACT_MAX;
          react_time_nxt   = REACT_MAX;
          result_valid_nxt = 1'b1;
        end else begin
          react_cnt_nxt = react_cnt + REACT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == SEQ) || (state_nxt == HOLD) || (state_nxt == MEASURE);
  end

endmodule

`default_nettype wire
